afifo_flow_ctrl: RTL and testbench
==================================

# afifo_flow_ctrl

Single-clock controller for the 128-bit MM2S asynchronous FIFO. It sits between the DMA MM2S stream and the FIFO write port, in the `s_axis_mm2s_aclk` domain, and does four jobs: sequences the FIFO's `fifo_en` and `soft_rst_n` inputs, gates the DMA-to-FIFO tvalid/tready handshake with almost-full hysteresis, stops streams only at packet boundaries, and performs flush/soft-reset sequences. tdata and tlast are wired straight from the DMA to the FIFO. This block only observes tlast and never touches data.

## Interface
Parameters:
- `RST_CYCLES`, default 8: soft reset low time in cycles. Legal range is 2..255.
- `PAUSE_HOLD`, default 4: number of consecutive cycles almost-full must be low before resuming. Legal range is 1..255.
- `PKT_CNT_W`, default 16: width of the packet counter.
- `SYNC_STAGES`, default 2: flop stages in the almost-empty synchronizer.

Ports (clock and reset first):
- `s_axis_mm2s_aclk` in 1: the only clock.
- `mm2s_prmry_reset_in` in 1: synchronous, active-high reset.
- `ctrl_start` in 1: one-cycle pulse that begins streaming.
- `ctrl_stop` in 1: one-cycle pulse requesting a graceful stop at the next packet end.
- `ctrl_flush` in 1: one-cycle pulse that aborts streaming and soft-resets the FIFO.
- `dma_tvalid` in 1: DMA tvalid.
- `dma_tready` out 1: tready returned to the DMA.
- `dma_tlast` in 1: DMA tlast (observed only).
- `fifo_s_tvalid` out 1: tvalid driven to the FIFO slave port.
- `fifo_s_tready` in 1: FIFO slave tready.
- `afifo_almost_full` in 1: FIFO almost-full; already in this clock domain.
- `afifo_almost_empty` in 1: FIFO almost-empty; asynchronous, synchronized internally.
- `fifo_en` out 1: FIFO enable.
- `soft_rst_n` out 1: FIFO soft reset, active low.
- `busy` out 1: high in every state except IDLE.
- `ctrl_state` out 3: current state encoding.
- `pkt_count` out PKT_CNT_W: number of packets accepted by the FIFO.

## Operation
- States and encodings: IDLE=0, RUN=1, PAUSE=2, STOPPING=3, DRAIN=4, FLUSH=5.
- Gate behaviour:
  - When open: `fifo_s_tvalid = dma_tvalid` and `dma_tready = fifo_s_tready`.
  - When closed: both are 0.
- A beat is accepted when `fifo_s_tvalid && fifo_s_tready`.
- AXI stability rule: the gate may only close in a cycle where no beat is stalled, i.e. not `(fifo_s_tvalid && !fifo_s_tready)`. A pending close is deferred until that condition holds. FLUSH is the only exception: it closes the gate immediately.
- Command priority: `mm2s_prmry_reset_in` > `ctrl_flush` > `ctrl_stop` > `ctrl_start`.
  - `ctrl_start` outside IDLE is ignored.
  - `ctrl_stop` in IDLE, DRAIN or FLUSH is ignored.
  - `ctrl_flush` is honoured in every state, including FLUSH itself, where it restarts the reset count.
- State transitions:
  - IDLE: `fifo_en`=0, gate closed. `ctrl_start` → RUN and clears `pkt_count`.
  - RUN: `fifo_en`=1, gate open.
    - `afifo_almost_full`=1 → PAUSE.
    - `ctrl_stop` → STOPPING.
  - PAUSE: `fifo_en`=1, gate closed (subject to the stability rule). A hold counter counts consecutive cycles with almost-full low and resets to 0 on any high sample.
    - Counter reaches `PAUSE_HOLD` → RUN.
    - `ctrl_stop` → STOPPING with the pause condition retained.
  - STOPPING: `fifo_en`=1.
    - Gate is open unless almost-full hysteresis applies, using the same rules as PAUSE.
    - An accepted beat with `dma_tlast`=1 → DRAIN. If the accepted beat that triggered the stop request in the same cycle carries tlast, go directly to DRAIN.
  - DRAIN: `fifo_en`=1, gate closed. Synchronized almost-empty = 1 → IDLE.
  - FLUSH: `fifo_en`=0, `soft_rst_n`=0, gate closed. A down-counter loads `RST_CYCLES`. When it expires → IDLE with `soft_rst_n`=1.
- `pkt_count`:
  - Increments on each accepted beat with tlast.
  - Saturates at all-ones.
  - Cleared on start, on flush and on reset.

## Timing
- All outputs except the gate are registered. The gate is combinational from the registered gate-open flag and the handshake inputs.
- Values during reset:
  - State IDLE.
  - `fifo_en`=0, `soft_rst_n`=0, `busy`=0, `pkt_count`=0, `ctrl_state`=0.
  - `dma_tready`=0, `fifo_s_tvalid`=0.
- `soft_rst_n` rises to 1 on the first cycle after reset is released.
- Command latency: a command sampled at edge N produces its new state and outputs visible after edge N, i.e. during cycle N+1.
- Almost-full sampled high at edge N closes the gate in cycle N+1, provided no beat is stalled.
- Resume from PAUSE: the gate reopens `PAUSE_HOLD`+1 cycles after the first low sample of almost-full.
- Almost-empty adds `SYNC_STAGES` cycles of latency before DRAIN exits.
- FLUSH holds `soft_rst_n` low for exactly `RST_CYCLES` cycles. The state is IDLE on the following cycle.
- Reset asserted mid-FLUSH or mid-packet: everything returns to reset values on the next edge.

## Configuration
- Macro: `AFIFO_CTRL_PKT_CNT_EN`.
- Defined: the `pkt_count` counter is implemented as described above.
- Undefined: the counter logic is removed and `pkt_count` is tied to 0. All other behaviour is unchanged.

## Structure
- Shared package `afifo_ctrl_pkg` holds:
  - the state enum with the encodings listed under Operation;
  - the default parameter constants.
- Sub-module `afifo_sync_bit`: a `SYNC_STAGES`-deep flop synchronizer for `afifo_almost_empty`, with no reset on the data flops.

## Test plan
- Reset then `ctrl_start`: `ctrl_state` goes 0→1 in one cycle and `fifo_en`=1. Send 3 packets of 4 beats with `fifo_s_tready`=1: `pkt_count`=3 and no beats are dropped.
- In RUN, raise `afifo_almost_full` while a beat is stalled (`fifo_s_tready`=0 for 3 cycles):
  - `fifo_s_tvalid` stays 1 until acceptance, then the gate closes.
  - Lower almost-full: the gate reopens after 5 cycles (`PAUSE_HOLD`=4).
- `ctrl_stop` issued mid-packet (beat 2 of 4): beats 3 and 4 are accepted, then DRAIN. Assert almost-empty: IDLE after 2+1 cycles and `fifo_en`=0.
- `ctrl_flush` during RUN with a stalled beat: the gate closes in the next cycle, `soft_rst_n`=0 for exactly 8 cycles, then IDLE and `pkt_count`=0.
- Simultaneous `ctrl_flush` and `ctrl_stop` in RUN: FLUSH wins. `ctrl_start` during FLUSH: ignored, and the state stays FLUSH.
- Drive 65536 packets with `PKT_CNT_W`=16: `pkt_count` saturates at 0xFFFF. With the macro undefined: `pkt_count` stays 0 throughout.

Source files
------------

// File: rtl/afifo_ctrl_pkg.sv
// Shared types and default parameters for the MM2S async-FIFO flow controller.
package afifo_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_PAUSE    = 3'd2,
        ST_STOPPING = 3'd3,
        ST_DRAIN    = 3'd4,
        ST_FLUSH    = 3'd5
    } ctrl_state_t;

    localparam int unsigned DEF_RST_CYCLES  = 8;
    localparam int unsigned DEF_PAUSE_HOLD  = 4;
    localparam int unsigned DEF_PKT_CNT_W   = 16;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned CTRL_CNT_W      = 8;

endpackage

// File: rtl/afifo_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level; data flops carry no reset.
module afifo_sync_bit
    import afifo_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_ff;

    always_ff @(posedge clk) begin
        sync_ff[0] <= d;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_ff[i] <= sync_ff[i-1];
        end
    end

    assign q = sync_ff[SYNC_STAGES-1];

endmodule

// File: rtl/afifo_flow_ctrl.sv
// Flow controller between the DMA MM2S stream and the async FIFO write port.
// Optional packet counter enabled by defining AFIFO_CTRL_PKT_CNT_EN.
module afifo_flow_ctrl
    import afifo_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES  = DEF_RST_CYCLES,
    parameter int unsigned PAUSE_HOLD  = DEF_PAUSE_HOLD,
    parameter int unsigned PKT_CNT_W   = DEF_PKT_CNT_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                 s_axis_mm2s_aclk,
    input  logic                 mm2s_prmry_reset_in,
    input  logic                 ctrl_start,
    input  logic                 ctrl_stop,
    input  logic                 ctrl_flush,
    input  logic                 dma_tvalid,
    output logic                 dma_tready,
    input  logic                 dma_tlast,
    output logic                 fifo_s_tvalid,
    input  logic                 fifo_s_tready,
    input  logic                 afifo_almost_full,
    input  logic                 afifo_almost_empty,
    output logic                 fifo_en,
    output logic                 soft_rst_n,
    output logic                 busy,
    output logic [2:0]           ctrl_state,
    output logic [PKT_CNT_W-1:0] pkt_count
);

    ctrl_state_t           state;
    logic                  gate_open;
    logic                  paused;
    logic                  paused_n;
    logic [CTRL_CNT_W-1:0] hold_cnt;
    logic [CTRL_CNT_W-1:0] hold_cnt_n;
    logic [CTRL_CNT_W-1:0] rst_cnt;
    logic                  ae_sync;
    logic                  stall;
    logic                  accept;

    afifo_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_ae_sync (
        .clk (s_axis_mm2s_aclk),
        .d   (afifo_almost_empty),
        .q   (ae_sync)
    );

    assign fifo_s_tvalid = gate_open & dma_tvalid;
    assign dma_tready    = gate_open & fifo_s_tready;
    assign stall         = fifo_s_tvalid & ~fifo_s_tready;
    assign accept        = fifo_s_tvalid & fifo_s_tready;
    assign ctrl_state    = state;

    // Almost-full hysteresis shared by RUN, PAUSE and STOPPING.
    always_comb begin
        paused_n   = paused;
        hold_cnt_n = hold_cnt;
        if (!paused) begin
            if (afifo_almost_full) begin
                paused_n   = 1'b1;
                hold_cnt_n = '0;
            end
        end else if (hold_cnt == CTRL_CNT_W'(PAUSE_HOLD)) begin
            paused_n   = 1'b0;
            hold_cnt_n = '0;
        end else if (afifo_almost_full) begin
            hold_cnt_n = '0;
        end else begin
            hold_cnt_n = hold_cnt + CTRL_CNT_W'(1);
        end
    end

    always_ff @(posedge s_axis_mm2s_aclk) begin
        if (mm2s_prmry_reset_in) begin
            state      <= ST_IDLE;
            gate_open  <= 1'b0;
            paused     <= 1'b0;
            hold_cnt   <= '0;
            rst_cnt    <= '0;
            fifo_en    <= 1'b0;
            soft_rst_n <= 1'b0;
            busy       <= 1'b0;
        end else if (ctrl_flush) begin
            // Flush closes the gate at once, even on a stalled beat.
            state      <= ST_FLUSH;
            gate_open  <= 1'b0;
            paused     <= 1'b0;
            hold_cnt   <= '0;
            rst_cnt    <= CTRL_CNT_W'(RST_CYCLES);
            fifo_en    <= 1'b0;
            soft_rst_n <= 1'b0;
            busy       <= 1'b1;
        end else begin
            soft_rst_n <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (ctrl_start) begin
                        state     <= ST_RUN;
                        gate_open <= 1'b1;
                        paused    <= 1'b0;
                        hold_cnt  <= '0;
                        fifo_en   <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_RUN, ST_PAUSE, ST_STOPPING: begin
                    paused   <= paused_n;
                    hold_cnt <= hold_cnt_n;
                    if (accept && dma_tlast && (ctrl_stop || state == ST_STOPPING)) begin
                        state     <= ST_DRAIN;
                        gate_open <= 1'b0;
                    end else begin
                        if (ctrl_stop || state == ST_STOPPING) begin
                            state <= ST_STOPPING;
                        end else begin
                            state <= paused_n ? ST_PAUSE : ST_RUN;
                        end
                        // A stalled beat keeps the gate open until it is taken.
                        gate_open <= ~paused_n | stall;
                    end
                end
                ST_DRAIN: begin
                    gate_open <= 1'b0;
                    if (ae_sync) begin
                        state   <= ST_IDLE;
                        fifo_en <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (rst_cnt <= CTRL_CNT_W'(1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        rst_cnt    <= rst_cnt - CTRL_CNT_W'(1);
                        soft_rst_n <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    gate_open <= 1'b0;
                    fifo_en   <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef AFIFO_CTRL_PKT_CNT_EN
    // Saturating count of packets accepted by the FIFO.
    always_ff @(posedge s_axis_mm2s_aclk) begin
        if (mm2s_prmry_reset_in || ctrl_flush || (state == ST_IDLE && ctrl_start)) begin
            pkt_count <= '0;
        end else if (accept && dma_tlast && (pkt_count != '1)) begin
            pkt_count <= pkt_count + PKT_CNT_W'(1);
        end
    end
`else
    assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_afifo_flow_ctrl.sv
// Scoreboard bench for afifo_flow_ctrl: beat ids queued when presented, popped on FIFO accept.
module tb_afifo_flow_ctrl;

    logic        clk = 1'b0;
    logic        mm2s_prmry_reset_in;
    logic        ctrl_start, ctrl_stop, ctrl_flush;
    logic        dma_tvalid, dma_tready, dma_tlast;
    logic        fifo_s_tvalid, fifo_s_tready;
    logic        afifo_almost_full, afifo_almost_empty;
    logic        fifo_en, soft_rst_n, busy;
    logic [2:0]  ctrl_state;
    logic [15:0] pkt_count;

    always #5 clk = ~clk;

    afifo_flow_ctrl dut (
        .s_axis_mm2s_aclk    (clk),
        .mm2s_prmry_reset_in (mm2s_prmry_reset_in),
        .ctrl_start          (ctrl_start),
        .ctrl_stop           (ctrl_stop),
        .ctrl_flush          (ctrl_flush),
        .dma_tvalid          (dma_tvalid),
        .dma_tready          (dma_tready),
        .dma_tlast           (dma_tlast),
        .fifo_s_tvalid       (fifo_s_tvalid),
        .fifo_s_tready       (fifo_s_tready),
        .afifo_almost_full   (afifo_almost_full),
        .afifo_almost_empty  (afifo_almost_empty),
        .fifo_en             (fifo_en),
        .soft_rst_n          (soft_rst_n),
        .busy                (busy),
        .ctrl_state          (ctrl_state),
        .pkt_count           (pkt_count)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned sb_q[$];
    int unsigned next_id = 0;
    int unsigned cur_id = 0;
    int unsigned beats_left = 0;
    int unsigned pkt_len = 4;
    int unsigned cur_pos = 0;
    bit          cur_valid = 1'b0;
    logic        sm_ftv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, want);
        end
    endtask

    function automatic logic [31:0] exp_pkt(input int unsigned n);
`ifdef AFIFO_CTRL_PKT_CNT_EN
        return 32'(n);
`else
        return 32'(n & 0);
`endif
    endfunction

    task automatic present();
        if (!cur_valid && beats_left != 0) begin
            cur_valid = 1'b1;
            cur_id    = next_id;
            next_id++;
            beats_left--;
            sb_q.push_back(cur_id);
        end
        dma_tvalid = cur_valid;
        dma_tlast  = cur_valid && (cur_pos == pkt_len - 1);
    endtask

    // One clock: drive, sample before the rising edge, advance on DMA handshake.
    task automatic step();
        logic        dhs, fhs;
        int unsigned popped;
        present();
        #3;
        sm_ftv = fifo_s_tvalid;
        dhs    = dma_tvalid && dma_tready;
        fhs    = fifo_s_tvalid && fifo_s_tready;
        if (fhs) begin
            popped = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hFFFF_FFFF;
            chk("sb_beat_id", 32'(cur_id), 32'(popped));
        end
        @(negedge clk);
        if (dhs) begin
            cur_valid = 1'b0;
            cur_pos   = (cur_pos == pkt_len - 1) ? 0 : cur_pos + 1;
        end
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned k = 0;
        while ((beats_left != 0 || cur_valid) && k < budget) begin
            step();
            k++;
        end
        chk("drain_timeout", 32'(beats_left != 0 || cur_valid), 32'd0);
    endtask

    task automatic count_flush(input string tag);
        int unsigned n_low = 1;
        int unsigned k = 0;
        while (!soft_rst_n && k < 40) begin
            step();
            k++;
            if (!soft_rst_n) n_low++;
        end
        chk(tag, 32'(n_low), 32'd8);
        chk("flush_exit_state", 32'(ctrl_state), 32'd0);
    endtask

    task automatic pulse_start();
        ctrl_start = 1'b1;
        step();
        ctrl_start = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        mm2s_prmry_reset_in = 1'b1;
        ctrl_start = 1'b0; ctrl_stop = 1'b0; ctrl_flush = 1'b0;
        dma_tvalid = 1'b0; dma_tlast = 1'b0; fifo_s_tready = 1'b1;
        afifo_almost_full = 1'b0; afifo_almost_empty = 1'b0;
        @(negedge clk);
        repeat (3) step();
        chk("rst_state", 32'(ctrl_state), 32'd0);
        chk("rst_fifo_en", 32'(fifo_en), 32'd0);
        chk("rst_soft_rst_n", 32'(soft_rst_n), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pkt", 32'(pkt_count), 32'd0);
        chk("rst_dma_tready", 32'(dma_tready), 32'd0);
        dma_tvalid = 1'b1;
        #1;
        chk("rst_fifo_tvalid", 32'(fifo_s_tvalid), 32'd0);
        mm2s_prmry_reset_in = 1'b0;
        step();
        chk("post_rst_soft_rst_n", 32'(soft_rst_n), 32'd1);
        ctrl_stop = 1'b1; step(); ctrl_stop = 1'b0;
        chk("idle_stop_ignored", 32'(ctrl_state), 32'd0);

        // Start and three 4-beat packets
        pulse_start();
        chk("start_state", 32'(ctrl_state), 32'd1);
        chk("start_fifo_en", 32'(fifo_en), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        beats_left = 12;
        drain(100);
        chk("pkt_after_3", 32'(pkt_count), exp_pkt(3));
        chk("sb_empty_1", 32'(sb_q.size()), 32'd0);

        // Almost-full while a beat is stalled
        fifo_s_tready = 1'b0;
        beats_left = 4;
        step();
        afifo_almost_full = 1'b1;
        step();
        chk("pause_state", 32'(ctrl_state), 32'd2);
        chk("pause_stall_tvalid", 32'(fifo_s_tvalid), 32'd1);
        step();
        chk("pause_stall_tvalid2", 32'(fifo_s_tvalid), 32'd1);
        fifo_s_tready = 1'b1;
        step();
        chk("pause_closed_tvalid", 32'(fifo_s_tvalid), 32'd0);
        chk("pause_closed_tready", 32'(dma_tready), 32'd0);
        repeat (3) begin
            step();
            chk("pause_hold_closed", 32'(sm_ftv), 32'd0);
        end
        afifo_almost_full = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("resume_wait", 32'(sm_ftv), 32'd0);
        end
        chk("resume_state", 32'(ctrl_state), 32'd1);
        step();
        chk("resume_open", 32'(sm_ftv), 32'd1);
        drain(50);
        chk("pkt_after_4", 32'(pkt_count), exp_pkt(4));
        chk("sb_empty_2", 32'(sb_q.size()), 32'd0);

        // Almost-full with nothing stalled closes on the next cycle
        afifo_almost_full = 1'b1;
        step();
        chk("af_pause_state", 32'(ctrl_state), 32'd2);
        chk("af_gate_closed", 32'(dma_tready), 32'd0);
        afifo_almost_full = 1'b0;
        repeat (5) step();
        chk("af_resume_state", 32'(ctrl_state), 32'd1);
        chk("af_reopen", 32'(dma_tready), 32'd1);

        // Graceful stop on beat 2 of 4, then drain
        beats_left = 4;
        step();
        ctrl_stop = 1'b1; step(); ctrl_stop = 1'b0;
        chk("stop_state", 32'(ctrl_state), 32'd3);
        step();
        chk("stop_state2", 32'(ctrl_state), 32'd3);
        step();
        chk("drain_state", 32'(ctrl_state), 32'd4);
        chk("drain_fifo_en", 32'(fifo_en), 32'd1);
        chk("stop_beats_done", 32'(beats_left) + 32'(cur_valid), 32'd0);
        afifo_almost_empty = 1'b1;
        step(); step();
        chk("drain_hold", 32'(ctrl_state), 32'd4);
        step();
        chk("ae_idle", 32'(ctrl_state), 32'd0);
        chk("ae_fifo_en", 32'(fifo_en), 32'd0);
        chk("ae_busy", 32'(busy), 32'd0);
        chk("pkt_after_5", 32'(pkt_count), exp_pkt(5));
        afifo_almost_empty = 1'b0;
        step(); step();

        // Flush during RUN with a stalled beat
        pulse_start();
        chk("start_pkt_clr", 32'(pkt_count), exp_pkt(0));
        beats_left = 4;
        drain(50);
        chk("pkt_before_flush", 32'(pkt_count), exp_pkt(1));
        fifo_s_tready = 1'b0;
        beats_left = 4;
        step();
        ctrl_flush = 1'b1; step(); ctrl_flush = 1'b0;
        chk("flush_state", 32'(ctrl_state), 32'd5);
        chk("flush_soft_rst_n", 32'(soft_rst_n), 32'd0);
        chk("flush_fifo_en", 32'(fifo_en), 32'd0);
        chk("flush_gate", 32'(fifo_s_tvalid), 32'd0);
        chk("flush_pkt_clr", 32'(pkt_count), 32'd0);
        cur_valid = 1'b0; cur_pos = 0; beats_left = 0;
        sb_q.delete();
        fifo_s_tready = 1'b1;
        count_flush("flush_len");

        // Flush beats stop; start ignored in FLUSH; flush restarts count
        pulse_start();
        ctrl_flush = 1'b1; ctrl_stop = 1'b1; step();
        ctrl_flush = 1'b0; ctrl_stop = 1'b0;
        chk("prio_flush_state", 32'(ctrl_state), 32'd5);
        pulse_start();
        chk("start_in_flush", 32'(ctrl_state), 32'd5);
        step();
        ctrl_flush = 1'b1; step(); ctrl_flush = 1'b0;
        chk("reflush_state", 32'(ctrl_state), 32'd5);
        count_flush("reflush_len");

        // Reset in the middle of FLUSH
        pulse_start();
        ctrl_flush = 1'b1; step(); ctrl_flush = 1'b0;
        step();
        mm2s_prmry_reset_in = 1'b1; step();
        chk("midrst_state", 32'(ctrl_state), 32'd0);
        chk("midrst_soft_rst_n", 32'(soft_rst_n), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_fifo_en", 32'(fifo_en), 32'd0);
        mm2s_prmry_reset_in = 1'b0; step();
        chk("midrst_release", 32'(soft_rst_n), 32'd1);

        // Packet counter saturation with single-beat packets
        pulse_start();
        chk("sat_start_pkt", 32'(pkt_count), 32'd0);
        pkt_len = 1;
        beats_left = 65535;
        drain(70000);
        chk("sat_reach", 32'(pkt_count), exp_pkt(32'hFFFF));
        beats_left = 5;
        drain(20);
        chk("sat_hold", 32'(pkt_count), exp_pkt(32'hFFFF));
        chk("sb_empty_end", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
